// File: rtl/fifo_tx_serializer_pkg.sv
// Shared types and helpers for the FIFO-fed serial transmitter.
// The PARITY state exists only when FIFO_TX_PARITY_EN is defined.
package fifo_tx_pkg;

    localparam int PAR_MAX_W = 64;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_START  = 3'd2,
        ST_DATA   = 3'd3,
`ifdef FIFO_TX_PARITY_EN
        ST_PARITY = 3'd4,
`endif
        ST_STOP   = 3'd5
    } state_t;

    // Even-parity bit of a word; zero-extension to PAR_MAX_W leaves the XOR unchanged.
    function automatic logic parity_even(input logic [PAR_MAX_W-1:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/fifo_tx_serializer_bit_timer.sv
// Bit-period timer: ticks on the last clk cycle of every CLKS_PER_BIT-cycle bit time.
// A restart pulse realigns the period so the next bit starts at count zero.
module bit_timer #(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic clk,
    input  logic i_reset,
    input  logic i_restart,
    output logic o_tick
);

    localparam int CW = $clog2(CLKS_PER_BIT);

    logic [CW-1:0] r_cnt;

    assign o_tick = (r_cnt == CW'(CLKS_PER_BIT - 1));

    always_ff @(posedge clk) begin
        if (i_reset || i_restart || o_tick) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

endmodule

// File: rtl/fifo_tx_serializer.sv
// Serialises words fetched from an upstream FIFO: start bit, WIDTH data bits LSB-first, stop bit.
// Define FIFO_TX_PARITY_EN to insert an even-parity bit between the data bits and the stop bit.
module fifo_tx_serializer
    import fifo_tx_pkg::*;
#(
    parameter int WIDTH        = 8,
    parameter int CLKS_PER_BIT = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             fifo_empty,
    input  logic [WIDTH-1:0] fifo_data,
    output logic             fifo_rd_req,
    output logic             tx,
    output logic             busy,
    output logic             done
);

    localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    state_t           r_state;
    state_t           w_state_next;
    logic [WIDTH-1:0] r_shreg;
    logic [WIDTH-1:0] w_shreg_next;
    logic [BW-1:0]    r_bit_cnt;
    logic [BW-1:0]    w_bit_cnt_next;
    logic             r_tx;
    logic             w_tx_next;
    logic             w_tick;
    logic             w_restart;
`ifdef FIFO_TX_PARITY_EN
    logic             r_parity;
    logic             w_parity_next;
`endif

    bit_timer #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_bit_timer (
        .clk       (clk),
        .i_reset   (reset),
        .i_restart (w_restart),
        .o_tick    (w_tick)
    );

    assign busy = (r_state != ST_IDLE);
    assign tx   = r_tx;

    always_comb begin
        w_state_next   = r_state;
        w_shreg_next   = r_shreg;
        w_bit_cnt_next = r_bit_cnt;
        w_restart      = 1'b0;
        fifo_rd_req    = 1'b0;
        done           = 1'b0;
`ifdef FIFO_TX_PARITY_EN
        w_parity_next  = r_parity;
`endif
        case (r_state)
            ST_IDLE: begin
                // Reset gates the request so no word is popped and then lost.
                if (enable && !fifo_empty && !reset) begin
                    fifo_rd_req  = 1'b1;
                    w_state_next = ST_LOAD;
                end
            end
            ST_LOAD: begin
                w_shreg_next   = fifo_data;
                w_bit_cnt_next = '0;
                w_restart      = 1'b1;
`ifdef FIFO_TX_PARITY_EN
                w_parity_next  = parity_even(PAR_MAX_W'(fifo_data));
`endif
                w_state_next   = ST_START;
            end
            ST_START: begin
                if (w_tick) w_state_next = ST_DATA;
            end
            ST_DATA: begin
                if (w_tick) begin
                    w_shreg_next   = r_shreg >> 1;
                    w_bit_cnt_next = r_bit_cnt + BW'(1);
                    if (r_bit_cnt == BW'(WIDTH - 1)) begin
`ifdef FIFO_TX_PARITY_EN
                        w_state_next = ST_PARITY;
`else
                        w_state_next = ST_STOP;
`endif
                    end
                end
            end
`ifdef FIFO_TX_PARITY_EN
            ST_PARITY: begin
                if (w_tick) w_state_next = ST_STOP;
            end
`endif
            ST_STOP: begin
                if (w_tick) begin
                    done         = 1'b1;
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase

        // tx is registered, so it is derived from the state being entered.
        case (w_state_next)
            ST_START:  w_tx_next = 1'b0;
            ST_DATA:   w_tx_next = w_shreg_next[0];
`ifdef FIFO_TX_PARITY_EN
            ST_PARITY: w_tx_next = w_parity_next;
`endif
            default:   w_tx_next = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_shreg   <= '0;
            r_bit_cnt <= '0;
            r_tx      <= 1'b1;
`ifdef FIFO_TX_PARITY_EN
            r_parity  <= 1'b0;
`endif
        end else begin
            r_state   <= w_state_next;
            r_shreg   <= w_shreg_next;
            r_bit_cnt <= w_bit_cnt_next;
            r_tx      <= w_tx_next;
`ifdef FIFO_TX_PARITY_EN
            r_parity  <= w_parity_next;
`endif
        end
    end

endmodule

// File: tb/tb_fifo_tx_serializer.sv
// Self-checking bench for fifo_tx_serializer with a queue-based FIFO and a frame-waveform model.
// Honours FIFO_TX_PARITY_EN when the design is built with it.
module tb_fifo_tx_serializer;

    localparam int WIDTH = 8;
    localparam int CPB   = 4;
`ifdef FIFO_TX_PARITY_EN
    localparam int NBITS = WIDTH + 3;
`else
    localparam int NBITS = WIDTH + 2;
`endif
    localparam int FRAME = NBITS * CPB;

    logic             clk = 1'b0;
    logic             reset;
    logic             enable;
    logic             fifo_empty;
    logic [WIDTH-1:0] fifo_data;
    logic             fifo_rd_req;
    logic             tx;
    logic             busy;
    logic             done;

    int n_checks = 0;
    int n_fail   = 0;
    int rd_count = 0;
    logic             g_grant;
    logic [WIDTH-1:0] fifo_q[$];
    logic             exp_tx[0:FRAME];

    fifo_tx_serializer #(
        .WIDTH        (WIDTH),
        .CLKS_PER_BIT (CPB)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .fifo_empty  (fifo_empty),
        .fifo_data   (fifo_data),
        .fifo_rd_req (fifo_rd_req),
        .tx          (tx),
        .busy        (busy),
        .done        (done)
    );

    initial forever #5 clk = ~clk;

    // Upstream FIFO: a read granted at a rising edge pops the head during the following cycle.
    initial begin
        fifo_empty = 1'b1;
        fifo_data  = '0;
        forever begin
            @(posedge clk);
            g_grant = fifo_rd_req;
            @(negedge clk);
            if (g_grant) begin
                rd_count++;
                if (fifo_q.size() > 0) fifo_data = fifo_q.pop_front();
                fifo_empty = (fifo_q.size() == 0);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1);
    end

    task automatic push(input logic [WIDTH-1:0] w);
        fifo_q.push_back(w);
        fifo_empty = 1'b0;
    endtask

    // Expected tx per cycle after the read-request cycle: LOAD (idle high), start, data, [parity], stop.
    task automatic build_frame(input logic [WIDTH-1:0] w);
        int p;
        p = 0;
        exp_tx[p] = 1'b1; p++;
        for (int k = 0; k < CPB; k++) begin exp_tx[p] = 1'b0; p++; end
        for (int b = 0; b < WIDTH; b++)
            for (int k = 0; k < CPB; k++) begin exp_tx[p] = w[b]; p++; end
`ifdef FIFO_TX_PARITY_EN
        for (int k = 0; k < CPB; k++) begin exp_tx[p] = ^w; p++; end
`endif
        for (int k = 0; k < CPB; k++) begin exp_tx[p] = 1'b1; p++; end
    endtask

    // Advances to the cycle in which fifo_rd_req is high; waited = negedges advanced, -1 on timeout.
    task automatic wait_rd(input int limit, output int waited);
        waited = 0;
        #1;
        while (!fifo_rd_req && waited < limit) begin
            @(negedge clk); #1;
            waited++;
        end
        if (!fifo_rd_req) waited = -1;
    endtask

    task automatic test_reset();
        reset  = 1'b1;
        enable = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({tx, busy, done, fifo_rd_req} !== 4'b1000) begin
            n_fail++;
            $display("FAIL reset_hold got tx/busy/done/rd=%b want 1000", {tx, busy, done, fifo_rd_req});
        end
        reset = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            n_checks++;
            if ({tx, busy, done, fifo_rd_req} !== 4'b1000) begin
                n_fail++;
                $display("FAIL reset_idle cyc=%0d got tx/busy/done/rd=%b want 1000", i, {tx, busy, done, fifo_rd_req});
            end
        end
    endtask

    task automatic test_single_a5();
        int w, fall_i, done_i, rd0;
        rd0 = rd_count; fall_i = -1; done_i = -1;
        build_frame(8'hA5);
        push(8'hA5);
        wait_rd(5, w);
        n_checks++;
        if (w != 0) begin
            n_fail++;
            $display("FAIL a5_rd_req got wait=%0d want 0", w);
            return;
        end
        for (int i = 0; i <= FRAME; i++) begin
            @(negedge clk);
            if (tx === 1'b0 && fall_i < 0) fall_i = i;
            if (done === 1'b1) done_i = i;
            n_checks++;
            if ({tx, busy, done, fifo_rd_req} !== {exp_tx[i], 1'b1, (i == FRAME), 1'b0}) begin
                n_fail++;
                $display("FAIL a5_frame cyc=%0d got tx/busy/done/rd=%b want %b", i,
                         {tx, busy, done, fifo_rd_req}, {exp_tx[i], 1'b1, (i == FRAME), 1'b0});
            end
        end
        n_checks++;
        if (fall_i != 1 || done_i - fall_i + 1 != FRAME) begin
            n_fail++;
            $display("FAIL a5_timing got fall=%0d len=%0d want fall=1 len=%0d", fall_i, done_i - fall_i + 1, FRAME);
        end
        @(negedge clk);
        n_checks++;
        if ({tx, busy, done, fifo_rd_req} !== 4'b1000 || rd_count - rd0 != 1) begin
            n_fail++;
            $display("FAIL a5_after got tx/busy/done/rd=%b reads=%0d want 1000 reads=1",
                     {tx, busy, done, fifo_rd_req}, rd_count - rd0);
        end
    endtask

    task automatic test_back_to_back();
        int w, rd0;
        logic [WIDTH-1:0] words[2];
        words[0] = 8'h01; words[1] = 8'hFF;
        rd0 = rd_count;
        push(words[0]);
        push(words[1]);
        for (int k = 0; k < 2; k++) begin
            build_frame(words[k]);
            wait_rd(5, w);
            n_checks++;
            if (w != k || tx !== 1'b1 || busy !== (k == 0 ? 1'b0 : 1'b0)) begin
                n_fail++;
                $display("FAIL b2b_gap word=%0d got wait=%0d tx=%b busy=%b want wait=%0d tx=1 busy=0", k, w, tx, busy, k);
                return;
            end
            for (int i = 0; i <= FRAME; i++) begin
                @(negedge clk);
                n_checks++;
                if ({tx, busy, done, fifo_rd_req} !== {exp_tx[i], 1'b1, (i == FRAME), 1'b0}) begin
                    n_fail++;
                    $display("FAIL b2b_frame word=%0d cyc=%0d got tx/busy/done/rd=%b want %b", k, i,
                             {tx, busy, done, fifo_rd_req}, {exp_tx[i], 1'b1, (i == FRAME), 1'b0});
                end
            end
        end
        repeat (10) @(negedge clk);
        n_checks++;
        if (rd_count - rd0 != 2 || {tx, busy} !== 2'b10) begin
            n_fail++;
            $display("FAIL b2b_reads got reads=%0d tx/busy=%b want reads=2 tx/busy=10", rd_count - rd0, {tx, busy});
        end
    endtask

    task automatic test_enable_drop();
        int w;
        logic [WIDTH-1:0] r;
        r = WIDTH'($urandom);
        build_frame(8'h3C);
        push(8'h3C);
        push(r);
        wait_rd(5, w);
        n_checks++;
        if (w != 0) begin
            n_fail++;
            $display("FAIL en_rd_req got wait=%0d want 0", w);
            return;
        end
        for (int i = 0; i <= FRAME; i++) begin
            @(negedge clk);
            n_checks++;
            if ({tx, busy, done, fifo_rd_req} !== {exp_tx[i], 1'b1, (i == FRAME), 1'b0}) begin
                n_fail++;
                $display("FAIL en_frame cyc=%0d got tx/busy/done/rd=%b want %b", i,
                         {tx, busy, done, fifo_rd_req}, {exp_tx[i], 1'b1, (i == FRAME), 1'b0});
            end
            if (i == 1 + CPB + 3 * CPB + 1) enable = 1'b0;
        end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            n_checks++;
            if ({tx, busy, fifo_rd_req} !== 3'b100) begin
                n_fail++;
                $display("FAIL en_blocked cyc=%0d got tx/busy/rd=%b want 100", i, {tx, busy, fifo_rd_req});
            end
        end
        enable = 1'b1;
        build_frame(r);
        wait_rd(2, w);
        n_checks++;
        if (w != 0) begin
            n_fail++;
            $display("FAIL en_resume got wait=%0d want 0", w);
            return;
        end
        for (int i = 0; i <= FRAME; i++) begin
            @(negedge clk);
            n_checks++;
            if ({tx, busy, done, fifo_rd_req} !== {exp_tx[i], 1'b1, (i == FRAME), 1'b0}) begin
                n_fail++;
                $display("FAIL en_frame2 cyc=%0d got tx/busy/done/rd=%b want %b", i,
                         {tx, busy, done, fifo_rd_req}, {exp_tx[i], 1'b1, (i == FRAME), 1'b0});
            end
        end
    endtask

    task automatic test_reset_mid();
        int w, rd0;
        logic [WIDTH-1:0] r;
        r = WIDTH'($urandom);
        rd0 = rd_count;
        @(negedge clk);
        build_frame(r);
        push(r);
        wait_rd(5, w);
        n_checks++;
        if (w != 0) begin
            n_fail++;
            $display("FAIL rst_rd_req got wait=%0d want 0", w);
            return;
        end
        for (int i = 0; i <= 1 + CPB + 5 * CPB + 2; i++) begin
            @(negedge clk);
            n_checks++;
            if ({tx, busy, done} !== {exp_tx[i], 2'b10}) begin
                n_fail++;
                $display("FAIL rst_prefix cyc=%0d got tx/busy/done=%b want %b", i, {tx, busy, done}, {exp_tx[i], 2'b10});
            end
        end
        reset = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({tx, busy, done, fifo_rd_req} !== 4'b1000) begin
            n_fail++;
            $display("FAIL rst_mid got tx/busy/done/rd=%b want 1000", {tx, busy, done, fifo_rd_req});
        end
        reset = 1'b0;
        for (int i = 0; i < FRAME + 5; i++) begin
            @(negedge clk);
            n_checks++;
            if ({tx, busy, done, fifo_rd_req} !== 4'b1000) begin
                n_fail++;
                $display("FAIL rst_no_resend cyc=%0d got tx/busy/done/rd=%b want 1000", i, {tx, busy, done, fifo_rd_req});
            end
        end
        n_checks++;
        if (rd_count - rd0 != 1) begin
            n_fail++;
            $display("FAIL rst_reads got reads=%0d want 1", rd_count - rd0);
        end
    endtask

    task automatic test_random();
        int w, rd0;
        logic [WIDTH-1:0] words[5];
        rd0 = rd_count;
        for (int k = 0; k < 5; k++) begin
            words[k] = WIDTH'($urandom);
            push(words[k]);
        end
        for (int k = 0; k < 5; k++) begin
            build_frame(words[k]);
            wait_rd(5, w);
            n_checks++;
            if (w != (k == 0 ? 0 : 1)) begin
                n_fail++;
                $display("FAIL rand_gap word=%0d got wait=%0d want %0d", k, w, (k == 0 ? 0 : 1));
                return;
            end
            for (int i = 0; i <= FRAME; i++) begin
                @(negedge clk);
                n_checks++;
                if ({tx, busy, done, fifo_rd_req} !== {exp_tx[i], 1'b1, (i == FRAME), 1'b0}) begin
                    n_fail++;
                    $display("FAIL rand_frame word=%0h cyc=%0d got tx/busy/done/rd=%b want %b", words[k], i,
                             {tx, busy, done, fifo_rd_req}, {exp_tx[i], 1'b1, (i == FRAME), 1'b0});
                end
            end
        end
        repeat (5) @(negedge clk);
        n_checks++;
        if (rd_count - rd0 != 5 || {tx, busy} !== 2'b10) begin
            n_fail++;
            $display("FAIL rand_reads got reads=%0d tx/busy=%b want reads=5 tx/busy=10", rd_count - rd0, {tx, busy});
        end
    endtask

`ifdef FIFO_TX_PARITY_EN
    task automatic test_parity();
        int w, fall_i, done_i;
        fall_i = -1; done_i = -1;
        push(8'h07);
        wait_rd(5, w);
        n_checks++;
        if (w != 0) begin
            n_fail++;
            $display("FAIL par_rd_req got wait=%0d want 0", w);
            return;
        end
        for (int i = 0; i <= FRAME; i++) begin
            @(negedge clk);
            if (tx === 1'b0 && fall_i < 0) fall_i = i;
            if (done === 1'b1) done_i = i;
            if (i == 1 + CPB + WIDTH * CPB + 1) begin
                n_checks++;
                if (tx !== 1'b1) begin
                    n_fail++;
                    $display("FAIL par_bit got tx=%b want 1", tx);
                end
            end
        end
        n_checks++;
        if (done_i - fall_i + 1 != 44) begin
            n_fail++;
            $display("FAIL par_len got len=%0d want 44", done_i - fall_i + 1);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single_a5();
        test_back_to_back();
        test_enable_drop();
        test_reset_mid();
        test_random();
`ifdef FIFO_TX_PARITY_EN
        test_parity();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
